dup_adder_checker_60: RTL

DUP_ADDER_CHECKER_60 -- requirements
Module: dup_adder_checker_60

---
 rtl/dup_adder_checker_60.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dup_adder_checker_60.sv
// Duplicated-adder checker: complement-duplicate and parity-prediction checks.
// Define CHECKER_HALT_ON_ERR_EN to stop accepting words after a reported error.
module dup_adder_checker_60 #(
  parameter int WIDTH = 60,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] s_invert,
  input  logic             papb,
  input  logic             pab,
  input  logic             clear,
  output logic             out_valid,
  output logic             err_dup,
  output logic             err_par,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic             xfer;
  logic             v1_q;
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] sinv1_q;
  logic             papb1_q;
  logic             pab1_q;
  logic             dup_c;
  logic             par_c;
  logic             report_err;

  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= xfer;
    end
  end

  // Payload only moves on a transfer; its valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_q    <= s;
      sinv1_q <= s_invert;
      papb1_q <= papb;
      pab1_q  <= pab;
    end
  end

  assign dup_c = |(s1_q ~^ sinv1_q);
  assign par_c = (^s1_q) ^ papb1_q ^ pab1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      err_dup   <= 1'b0;
      err_par   <= 1'b0;
    end else begin
      out_valid <= v1_q;
      err_dup   <= v1_q & dup_c;
      err_par   <= v1_q & par_c;
    end
  end

  assign report_err = out_valid & (err_dup | err_par);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (clear) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (report_err) begin
      err_sticky <= 1'b1;
      if (err_count != {CNT_W{1'b1}}) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
`ifdef CHECKER_HALT_ON_ERR_EN
        if (!clear && report_err) begin
          state_d = HALT;
        end
`endif
      end
      HALT: begin
        if (clear) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

`ifdef CHECKER_HALT_ON_ERR_EN
  assign in_ready = (state_q == RUN);
`else
  assign in_ready = 1'b1;
`endif

endmodule
